// File: rtl/logic_issue_ctrl.sv
// Operand-issue and writeback controller for the 8-bit logic datapath:
// a small register file, a command FSM (IDLE/READ/EXEC/RESP) and a valid/ready response port.
module logic_issue_ctrl #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_rd,
  input  logic [AW-1:0]    cmd_ra,
  input  logic [AW-1:0]    cmd_rb,
  input  logic             ld_valid,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic [7:0]       op_count
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, RESP} state_t;

  state_t           state_q;
  logic [1:0]       op_q;
  logic [AW-1:0]    rd_q, ra_q, rb_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_zero_q;
  logic             rsp_valid_q;
  logic [7:0]       op_count_q;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] result_d;

  always_comb begin
    result_d = '0;
    case (op_q)
      2'd0:    result_d = a_q | b_q;
      2'd1:    result_d = a_q & b_q;
      2'd2:    result_d = a_q ^ b_q;
      default: result_d = a_q & ~b_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            rd_q    <= cmd_rd;
            ra_q    <= cmd_ra;
            rb_q    <= cmd_rb;
            state_q <= READ;
          end
        end
        READ: begin
          // Sources see pre-edge contents, so a same-edge load is not visible here.
          a_q     <= regs_q[ra_q];
          b_q     <= regs_q[rb_q];
          state_q <= EXEC;
        end
        EXEC: begin
          rsp_data_q  <= result_d;
          rsp_zero_q  <= (result_d == '0);
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + 8'd1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Writeback takes priority over a direct load to the same entry.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs_q[gi] <= '0;
      end else if (state_q == EXEC && rd_q == AW'(gi)) begin
        regs_q[gi] <= result_d;
      end else if (ld_valid && ld_addr == AW'(gi)) begin
        regs_q[gi] <= ld_data;
      end
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign op_count  = op_count_q;
  assign dbg_data  = regs_q[dbg_addr];

endmodule
